stream_downsizer: RTL and testbench
===================================

STREAM_DOWNSIZER -- requirements
Module: stream_downsizer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 128, meaning input word width in bits.
REQ-002 SHALL have parameter OUT_WIDTH, default 32, meaning output beat width in bits.
REQ-003 SHALL derive RATIO = IN_WIDTH/OUT_WIDTH; legal configurations are RATIO a power of two and >= 2; LEN_W = $clog2(RATIO).
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port w_valid_i, input, 1, upstream word valid; upstream is a stream FIFO read side.
REQ-007 SHALL have port w_ready_o, output, 1, word accepted when w_valid_i && w_ready_o.
REQ-008 SHALL have port w_data_i, input, IN_WIDTH, input word; beat k is bits [k*OUT_WIDTH +: OUT_WIDTH].
REQ-009 SHALL have port w_len_i, input, LEN_W, number of beats to emit minus one (0 means 1 beat, RATIO-1 means RATIO beats).
REQ-010 SHALL have port r_valid_o, output, 1, output beat valid.
REQ-011 SHALL have port r_ready_i, input, 1, beat consumed when r_valid_o && r_ready_i.
REQ-012 SHALL have port r_data_o, output, OUT_WIDTH, current beat.
REQ-013 SHALL have port r_last_o, output, 1, high on the final beat of the current word.
REQ-014 SHALL have port beat_idx_o, output, LEN_W, index of the beat currently presented.

Function
REQ-015 SHALL hold one word in a register set: data_q (IN_WIDTH), len_q (LEN_W), idx_q (LEN_W), full_q (1).
REQ-016 SHALL implement two states: EMPTY (full_q=0) and SEND (full_q=1).
REQ-017 SHALL drive r_valid_o = full_q, r_data_o = data_q[idx_q*OUT_WIDTH +: OUT_WIDTH], r_last_o = full_q && (idx_q == len_q), beat_idx_o = idx_q.
REQ-018 SHALL drive w_ready_o = !full_q || (r_ready_i && r_last_o); combinational path from r_ready_i to w_ready_o is permitted.
REQ-019 SHALL, on accept (w_valid_i && w_ready_o), load data_q = w_data_i, len_q = w_len_i, idx_q = 0, full_q = 1 at the next edge.
REQ-020 SHALL, on a non-last pop, increment idx_q by 1 and leave data_q, len_q, full_q unchanged.
REQ-021 SHALL, on a last pop without accept, set full_q = 0 and idx_q = 0 (SEND -> EMPTY).
REQ-022 SHALL, on last pop coinciding with accept, load the new word (stay in SEND) with no bubble cycle.
REQ-023 SHALL present the first beat of an accepted word in the cycle after acceptance (latency 1).
REQ-024 SHALL hold r_data_o, r_last_o, beat_idx_o stable while r_valid_o && !r_ready_i.
REQ-025 SHALL never wrap idx_q past len_q; idx_q <= len_q at all times in SEND.
REQ-026 SHALL sustain one beat per cycle with r_ready_i held high, and one input word per (w_len_i+1) cycles.
REQ-027 SHALL ignore w_data_i and w_len_i when w_valid_i is low or w_ready_o is low.
REQ-028 SHALL contain no data-path dependence on beats above len_q (unused high bits may hold any value).

Reset
REQ-029 SHALL, on rst_n low, asynchronously clear full_q, idx_q, len_q, data_q to 0, giving r_valid_o=0, r_last_o=0, r_data_o=0, beat_idx_o=0, w_ready_o=1.
REQ-030 SHALL, on reset mid-word, discard the remaining beats with no further output after reset release until a new word is accepted.
REQ-031 SHALL resume normal operation on the first clock edge after rst_n deasserts.

Verification
REQ-032 Full word: IN=128/OUT=32, accept 0x44443333_22221111_... style word 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, len=3, r_ready_i=1 -> beats AAAAAAAA, BBBBBBBB, CCCCCCCC, DDDDDDDD on cycles 1-4, r_last_o only on cycle 4, w_ready_o high only on cycle 4 and after.
REQ-033 Short word: len=0, data low beat 0x12345678 -> single beat 0x12345678 with r_last_o=1 on cycle 1, then r_valid_o=0.
REQ-034 Back-to-back: two words len=1 presented continuously, r_ready_i=1 -> 4 consecutive valid beats, no idle cycle, r_last_o on beats 2 and 4.
REQ-035 Backpressure: len=3, r_ready_i toggled 1,0,0,1,1,1 -> beat sequence 0,1,1,1,2,3 with data stable during stalls, w_ready_o=0 until beat 3 popped.
REQ-036 Reset mid-word: accept len=3, pop 2 beats, pulse rst_n low -> r_valid_o=0, beat_idx_o=0, w_ready_o=1 immediately; no beats emitted afterwards until new accept.
REQ-037 Random: random valid/ready/len traffic vs scoreboard model for 10k words -> every beat in order, correct count per word, r_last_o exactly once per word.

Source files
------------

// File: rtl/stream_downsizer.sv
// Stream downsizer: takes one wide word and emits it as a run of narrow beats,
// lowest beat first. The upstream w_len_i selects how many beats to send.
// One word is held at a time. A new word can be loaded in the same cycle that
// the last beat of the previous word is popped, so full-rate traffic has no gaps.
module stream_downsizer #(
    parameter  int IN_WIDTH  = 128,
    parameter  int OUT_WIDTH = 32,
    localparam int RATIO     = IN_WIDTH / OUT_WIDTH,
    localparam int LEN_W     = $clog2(RATIO)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    input  logic [IN_WIDTH-1:0]  w_data_i,
    input  logic [LEN_W-1:0]     w_len_i,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic [OUT_WIDTH-1:0] r_data_o,
    output logic                 r_last_o,
    output logic [LEN_W-1:0]     beat_idx_o
);

    typedef enum logic {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } state_t;

    state_t                 state_q;
    logic [IN_WIDTH-1:0]    data_q;
    logic [LEN_W-1:0]       len_q;
    logic [LEN_W-1:0]       idx_q;
    logic                   full_q;
    logic [OUT_WIDTH-1:0]   beats [RATIO];
    logic                   accept;
    logic                   pop;

    assign full_q = (state_q == SEND);

    // Split the held word into beat lanes so the current beat is a plain mux.
    always_comb begin
        for (int k = 0; k < RATIO; k++) begin
            beats[k] = data_q[k*OUT_WIDTH +: OUT_WIDTH];
        end
    end

    assign r_valid_o  = full_q;
    assign r_data_o   = beats[idx_q];
    assign r_last_o   = full_q && (idx_q == len_q);
    assign beat_idx_o = idx_q;

    // Ready when empty, or when the final beat is leaving this cycle.
    assign w_ready_o  = !full_q || (r_ready_i && r_last_o);

    assign accept     = w_valid_i && w_ready_o;
    assign pop        = full_q && r_ready_i;

    // Word holding register and beat walker; a load takes priority over draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
        end else if (accept) begin
            state_q <= SEND;
            data_q  <= w_data_i;
            len_q   <= w_len_i;
            idx_q   <= '0;
        end else if (pop && r_last_o) begin
            state_q <= EMPTY;
            idx_q   <= '0;
        end else if (pop) begin
            idx_q   <= idx_q + LEN_W'(1);
        end
    end

endmodule

// File: tb/tb_stream_downsizer.sv
// Testbench for stream_downsizer (128-bit words down to 32-bit beats).
// Every accepted word is expanded into expected beats on a queue; the DUT's
// presented beat is compared against the queue head every valid cycle.
module tb_stream_downsizer;

    localparam int IN_WIDTH  = 128;
    localparam int OUT_WIDTH = 32;
    localparam int LEN_W     = 2;
    localparam int RAND_WORDS = 10000;
    localparam int CYCLE_CAP  = 90000;

    typedef struct {
        logic [OUT_WIDTH-1:0] data;
        logic                 last;
        logic [LEN_W-1:0]     idx;
    } beat_t;

    logic                 clk;
    logic                 rst_n;
    logic                 w_valid_i;
    logic                 w_ready_o;
    logic [IN_WIDTH-1:0]  w_data_i;
    logic [LEN_W-1:0]     w_len_i;
    logic                 r_valid_o;
    logic                 r_ready_i;
    logic [OUT_WIDTH-1:0] r_data_o;
    logic                 r_last_o;
    logic [LEN_W-1:0]     beat_idx_o;

    beat_t sb[$];
    int    vectors;
    int    miscompares;
    int    words_accepted;

    stream_downsizer #(
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .w_valid_i (w_valid_i),
        .w_ready_o (w_ready_o),
        .w_data_i  (w_data_i),
        .w_len_i   (w_len_i),
        .r_valid_o (r_valid_o),
        .r_ready_i (r_ready_i),
        .r_data_o  (r_data_o),
        .r_last_o  (r_last_o),
        .beat_idx_o(beat_idx_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, check against the model just before the edge,
    // then advance the model by the handshakes that edge will perform.
    task automatic applyStimulus(input logic wv, input logic [IN_WIDTH-1:0] wd,
                                 input logic [LEN_W-1:0] wl, input logic rr);
        logic exp_ready;
        logic exp_pop;
        logic exp_accept;
        @(negedge clk);
        w_valid_i = wv;
        w_data_i  = wd;
        w_len_i   = wl;
        r_ready_i = rr;
        #4;
        exp_pop    = (sb.size() != 0) && rr;
        exp_ready  = (sb.size() == 0) || (rr && sb[0].last);
        exp_accept = wv && exp_ready;
        checkOutput("r_valid", 128'(r_valid_o), 128'(sb.size() != 0));
        checkOutput("w_ready", 128'(w_ready_o), 128'(exp_ready));
        if (sb.size() != 0) begin
            checkOutput("r_data", 128'(r_data_o), 128'(sb[0].data));
            checkOutput("r_last", 128'(r_last_o), 128'(sb[0].last));
            checkOutput("beat_idx", 128'(beat_idx_o), 128'(sb[0].idx));
        end
        if (exp_pop) void'(sb.pop_front());
        if (exp_accept) begin
            words_accepted++;
            for (int k = 0; k <= int'(wl); k++) begin
                beat_t b;
                b.data = wd[k*OUT_WIDTH +: OUT_WIDTH];
                b.last = (k == int'(wl));
                b.idx  = LEN_W'(k);
                sb.push_back(b);
            end
        end
        @(posedge clk);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_r_valid"}, 128'(r_valid_o), 128'(0));
        checkOutput({tag, "_r_last"}, 128'(r_last_o), 128'(0));
        checkOutput({tag, "_r_data"}, 128'(r_data_o), 128'(0));
        checkOutput({tag, "_beat_idx"}, 128'(beat_idx_o), 128'(0));
        checkOutput({tag, "_w_ready"}, 128'(w_ready_o), 128'(1));
    endtask

    initial begin
        logic [1:0] ready_pat [6];
        logic [IN_WIDTH-1:0] word;
        int cycles;

        vectors        = 0;
        miscompares    = 0;
        words_accepted = 0;
        w_valid_i = 1'b0;
        w_data_i  = '0;
        w_len_i   = '0;
        r_ready_i = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset");
        rst_n = 1'b1;

        $display("[TB] full word, len=3");
        word = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        applyStimulus(1'b1, word, 2'd3, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 2'd0, 1'b1);

        $display("[TB] short word, len=0");
        word = 128'hFFFFFFFF_EEEEEEEE_99999999_12345678;
        applyStimulus(1'b1, word, 2'd0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 2'd0, 1'b1);

        $display("[TB] back-to-back, len=1");
        applyStimulus(1'b1, 128'h0_0_22222222_11111111, 2'd1, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 128'h0_0_44444444_33333333, 2'd1, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 2'd0, 1'b1);

        $display("[TB] backpressure, len=3");
        ready_pat = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
        applyStimulus(1'b1, 128'h40404040_30303030_20202020_10101010, 2'd3, 1'b0);
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, 128'h80808080_70707070_60606060_50505050, 2'd2, ready_pat[i][0]);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 2'd0, 1'b1);

        $display("[TB] reset mid-word");
        applyStimulus(1'b1, 128'hA4A4A4A4_A3A3A3A3_A2A2A2A2_A1A1A1A1, 2'd3, 1'b1);
        applyStimulus(1'b0, '0, 2'd0, 1'b1);
        applyStimulus(1'b0, '0, 2'd0, 1'b1);
        @(negedge clk);
        w_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("midreset");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 2'd0, 1'b1);
        applyStimulus(1'b1, 128'hB4B4B4B4_B3B3B3B3_B2B2B2B2_B1B1B1B1, 2'd2, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 2'd0, 1'b1);

        $display("[TB] random traffic");
        words_accepted = 0;
        cycles = 0;
        while (words_accepted < RAND_WORDS && cycles < CYCLE_CAP) begin
            word = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(($urandom_range(9, 0) != 0), word, LEN_W'($urandom_range(3, 0)),
                          ($urandom_range(4, 0) != 0));
            cycles++;
        end
        checkOutput("random_words", 128'(words_accepted), 128'(RAND_WORDS));
        for (int i = 0; i < 8 && sb.size() != 0; i++) applyStimulus(1'b0, '0, 2'd0, 1'b1);
        checkOutput("drain_empty", 128'(sb.size()), 128'(0));
        applyStimulus(1'b0, '0, 2'd0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
